mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single-ported unified memory bus between the instruction-fetch requester (IF stage) and the data requester (MEM stage, driven by the EX/MEM register's MemRead/MemWrite, ALU result and rs2 data). It generates one global `stall` that freezes the PC and every pipeline register until all accesses pending in the current cycle have completed. A bus-ack timeout converts a hung access into an error completion.

## Interface
- `TIMEOUT`, default 255: cycles waited in a grant state for `bus_ack` before aborting; legal range 1..65535.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: instruction fetch pending; held stable while `stall`=1.
- `if_addr` in 32: fetch address.
- `if_rdata` out 32: fetched word, registered; holds until the next IF completion.
- `if_done` out 1: one-cycle pulse, `if_rdata` valid.
- `mem_rd` in 1: load pending (EX/MEM MemRead).
- `mem_wr` in 1: store pending (EX/MEM MemWrite).
- `mem_addr` in 32: data address (EX/MEM ALU result).
- `mem_wdata` in 32: store data (EX/MEM rs2 data).
- `mem_rdata` out 32: load data, registered; holds until the next MEM completion.
- `mem_done` out 1: one-cycle pulse.
- `stall` out 1: combinational; 1 freezes the whole pipeline.
- `bus_err` out 1: one-cycle pulse alongside `if_done`/`mem_done` when the access timed out.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: 1 means write.
- `bus_addr` out 32: bus address.
- `bus_wdata` out 32: bus write data.
- `bus_ack` in 1: access complete this cycle.
- `bus_rdata` in 32: read data, valid with `bus_ack`.

## Operation
- `mem_acc` = `mem_rd` | `mem_wr`.
  - If both are 1, the access is a write and `mem_rdata` is not updated.
- Served flags `if_srv` and `mem_srv` record that a requester was completed in the current stall window.
- `stall` = (`if_req` & ~`if_srv`) | (`mem_acc` & ~`mem_srv`).
- Both served flags clear on any edge where `stall`=0, i.e. when the pipeline advances.
- FSM states: IDLE, GNT_MEM, GNT_IF.
- **IDLE**
  - If `mem_acc` & ~`mem_srv`: latch `mem_addr`, `mem_wdata` and `bus_we`=`mem_wr` into the bus registers; go to GNT_MEM.
  - Else if `if_req` & ~`if_srv`: latch `if_addr` with `bus_we`=0; go to GNT_IF.
  - MEM has fixed priority. IF cannot starve because each requester is served at most once per window.
- **GNT_x**
  - `bus_req`=1; `bus_addr`, `bus_we` and `bus_wdata` stay stable.
  - On an edge with `bus_ack`=1: capture `bus_rdata` into `x_rdata` (skipped for writes), set `x_srv`, pulse `x_done` next cycle, go to IDLE.
- **Timeout**
  - A counter of width clog2(TIMEOUT+1) clears on grant entry and increments each GNT cycle without `bus_ack`.
  - On the edge where count = TIMEOUT-1 and `bus_ack`=0: abort. `x_rdata` is set to 0, `x_srv` is set, and `x_done` and `bus_err` pulse; go to IDLE.
- `bus_ack` while `bus_req`=0 is ignored.
- Async reset mid-access:
  - Immediate return to IDLE with the bus dropped.
  - Served flags cleared; no done pulse.

## Timing
- Reset values:
  - Outputs 0: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `if_rdata`, `mem_rdata`, `if_done`, `mem_done`, `bus_err`.
  - State IDLE, served flags 0.
  - `stall` follows its equation, so it is 1 if requests are present during reset.
- Request seen in IDLE at cycle 0: `bus_req`=1 from cycle 1.
- `bus_ack` at cycle k≥1: `x_done` at k+1; `bus_req`=0 at k+1.
- Single requester with zero-wait bus (ack in cycle 1): `stall`=1 in cycles 0–1, 0 in cycle 2, and the pipeline advances at the end of cycle 2.
- Both requesters pending at cycle 0 with zero-wait acks:
  - MEM: `bus_req` in cycle 1, `mem_done` in cycle 2.
  - IF: granted from IDLE in cycle 2, `bus_req` in cycle 3, `if_done` in cycle 4.
  - `stall`=1 through cycle 3.
- A new grant can be decided in the same cycle as a done pulse, since IDLE is entered then.
- Timeout: with no ack, `bus_req` is high for exactly TIMEOUT cycles; the done and `bus_err` pulse follows the last of them.

## Test plan
- Fetch only, ack in cycle 1, `if_addr`=0x100, `bus_rdata`=0x00500093 → `bus_req` in cycle 1 only, `if_done` and `if_rdata`=0x00500093 in cycle 2, `stall` high in cycles 0–1.
- Simultaneous store (addr 0x2000, data 0xDEADBEEF) and fetch 0x104, zero-wait → store first with `bus_we`=1; fetch `bus_req` in cycle 3; `stall` falls in cycle 4; `mem_rdata` unchanged.
- Load with 3-cycle ack latency (ack in cycle 3), `bus_rdata`=0x12345678 → `bus_addr` stable cycles 1–3, `mem_done` and `mem_rdata`=0x12345678 in cycle 4.
- `TIMEOUT`=4, load with `bus_ack` never asserted → `bus_req` high cycles 1–4; cycle 5: `mem_done`=1, `bus_err`=1, `mem_rdata`=0; `stall`=0 if no fetch is pending.
- Reset asserted in cycle 2 of a pending access → `bus_req` 0 immediately; no done pulse after release; the access is re-granted from IDLE.
- Spurious `bus_ack` in IDLE, and `mem_rd`=`mem_wr`=1 → ack ignored with no state change; access issued with `bus_we`=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between instruction
// fetch and data access. A global stall holds the pipeline until every access
// pending in the current window has completed. A hung bus access is aborted
// after TIMEOUT grant cycles and reported as an error completion.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stall,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_MEM = 2'd1,
    GNT_IF  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          req_reg, req_next;
  logic          we_reg, we_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [31:0]   if_rdata_reg, if_rdata_next;
  logic [31:0]   mem_rdata_reg, mem_rdata_next;
  logic          if_done_reg, if_done_next;
  logic          mem_done_reg, mem_done_next;
  logic          err_reg, err_next;
  logic          if_srv_reg, if_srv_next;
  logic          mem_srv_reg, mem_srv_next;

  logic mem_acc;
  logic timed_out;

  // A store wins when both MemRead and MemWrite are set.
  assign mem_acc   = mem_rd | mem_wr;
  // Abort on the last allowed grant cycle if the bus still has not answered.
  assign timed_out = (cnt_reg == CNT_LAST) & ~bus_ack;
  // Stall until each requester present this window has been served once.
  assign stall     = (if_req & ~if_srv_reg) | (mem_acc & ~mem_srv_reg);

  assign bus_req   = req_reg;
  assign bus_we    = we_reg;
  assign bus_addr  = addr_reg;
  assign bus_wdata = wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;
  assign if_done   = if_done_reg;
  assign mem_done  = mem_done_reg;
  assign bus_err   = err_reg;

  // State and bus/result registers; reset drops the bus at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      err_reg       <= 1'b0;
      if_srv_reg    <= 1'b0;
      mem_srv_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_reg       <= req_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
      if_done_reg   <= if_done_next;
      mem_done_reg  <= mem_done_next;
      err_reg       <= err_next;
      if_srv_reg    <= if_srv_next;
      mem_srv_reg   <= mem_srv_next;
    end
  end

  // Grant selection, ack/timeout completion and served-flag bookkeeping.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    req_next       = req_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    err_next       = 1'b0;
    // Served flags only live until the pipeline advances.
    if_srv_next    = stall ? if_srv_reg : 1'b0;
    mem_srv_next   = stall ? mem_srv_reg : 1'b0;

    case (state_reg)
      IDLE: begin
        // Data side has fixed priority; bus_ack is not looked at here.
        if (mem_acc && !mem_srv_reg) begin
          addr_next  = mem_addr;
          wdata_next = mem_wdata;
          we_next    = mem_wr;
          req_next   = 1'b1;
          cnt_next   = '0;
          state_next = GNT_MEM;
        end else if (if_req && !if_srv_reg) begin
          addr_next  = if_addr;
          we_next    = 1'b0;
          req_next   = 1'b1;
          cnt_next   = '0;
          state_next = GNT_IF;
        end
      end

      GNT_MEM: begin
        if (bus_ack || timed_out) begin
          state_next    = IDLE;
          req_next      = 1'b0;
          mem_srv_next  = 1'b1;
          mem_done_next = 1'b1;
          err_next      = timed_out;
          if (!bus_ack) begin
            mem_rdata_next = '0;
          end else if (!we_reg) begin
            mem_rdata_next = bus_rdata;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      GNT_IF: begin
        if (bus_ack || timed_out) begin
          state_next    = IDLE;
          req_next      = 1'b0;
          if_srv_next   = 1'b1;
          if_done_next  = 1'b1;
          err_next      = timed_out;
          if_rdata_next = bus_ack ? bus_rdata : 32'd0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives pipeline windows (fetch and/or data access) with
// a scheduled bus slave and checks every cycle against a transaction-level
// plan of when each access is granted, acknowledged or timed out.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .stall     (stall),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int win_no = 0;

  // Per-cycle plan of one window, indexed by cycle number within the window.
  logic        p_req  [64];
  logic        p_we   [64];
  logic [31:0] p_addr [64];
  logic [31:0] p_wd   [64];
  logic [31:0] p_rv   [64];
  logic        p_ack  [64];
  logic        p_ifd  [64];
  logic        p_memd [64];
  logic        p_err  [64];
  logic        p_uif  [64];
  logic        p_umem [64];
  logic [31:0] p_uval [64];
  int          t_cur;
  logic [31:0] m_if_rdata;
  logic [31:0] m_mem_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One access granted from IDLE at t_cur; lat is the grant cycle carrying the
  // ack, and anything beyond TO means the bus never answers.
  task automatic add_access(input logic is_mem, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input int lat);
    int  l;
    int  d;
    logic tmo;
    tmo = (lat > TO);
    l   = tmo ? TO : lat;
    for (int c = t_cur + 1; c <= t_cur + l; c++) begin
      p_req[c]  = 1'b1;
      p_we[c]   = we;
      p_addr[c] = addr;
      p_wd[c]   = wd;
    end
    if (!tmo) p_ack[t_cur + l] = 1'b1;
    d = t_cur + l + 1;
    p_err[d] = tmo;
    if (is_mem) p_memd[d] = 1'b1;
    else        p_ifd[d]  = 1'b1;
    if (tmo || !(is_mem && we)) begin
      if (is_mem) p_umem[d] = 1'b1;
      else        p_uif[d]  = 1'b1;
      p_uval[d] = tmo ? 32'd0 : p_rv[t_cur + l];
    end
    t_cur = d;
  endtask

  // Runs one pipeline window from IDLE until the pipeline advances.
  task automatic run_window(input logic ir, input logic rd, input logic wr,
                            input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd,
                            input int lm, input int li, input logic [31:0] rfix);
    int len;
    for (int c = 0; c < 64; c++) begin
      p_req[c] = 1'b0; p_we[c] = 1'b0; p_addr[c] = '0; p_wd[c] = '0;
      p_ack[c] = 1'b0; p_ifd[c] = 1'b0; p_memd[c] = 1'b0; p_err[c] = 1'b0;
      p_uif[c] = 1'b0; p_umem[c] = 1'b0; p_uval[c] = '0;
      p_rv[c]  = (rfix != 0) ? rfix : $urandom;
    end
    t_cur = 0;
    if (rd | wr) add_access(1'b1, wr, ma, wd, lm);
    if (ir)      add_access(1'b0, 1'b0, ia, 32'd0, li);
    len = t_cur + 1;

    if_req = ir; if_addr = ia;
    mem_rd = rd; mem_wr = wr; mem_addr = ma; mem_wdata = wd;
    for (int c = 0; c < len; c++) begin
      bus_rdata = p_rv[c];
      bus_ack   = p_ack[c] | (!p_req[c] && ($urandom_range(2) == 0));
      #4;
      if (p_uif[c])  m_if_rdata  = p_uval[c];
      if (p_umem[c]) m_mem_rdata = p_uval[c];
      check("stall", stall, (c < t_cur));
      check("bus_req", bus_req, p_req[c]);
      if (p_req[c]) begin
        check("bus_we", bus_we, p_we[c]);
        check("bus_addr", bus_addr, p_addr[c]);
        if (p_we[c]) check("bus_wdata", bus_wdata, p_wd[c]);
      end
      check("if_done", if_done, p_ifd[c]);
      check("mem_done", mem_done, p_memd[c]);
      check("bus_err", bus_err, p_err[c]);
      check("if_rdata", if_rdata, m_if_rdata);
      check("mem_rdata", mem_rdata, m_mem_rdata);
      @(posedge clk);
      #1;
    end
    bus_ack = 1'b0;
    $display("win %0d: if=%0b rd=%0b wr=%0b lat_m=%0d lat_i=%0d cycles=%0d",
             win_no, ir, rd, wr, lm, li, len);
    win_no++;
  endtask

  // Reset asserted while a load holds the bus, then the access is redone.
  task automatic reset_mid();
    if_req = 1'b1; if_addr = 32'h200;
    mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = 32'h4000; mem_wdata = 32'h0;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    check("rstmid_req_before", bus_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstmid_req", bus_req, 1'b0);
    check("rstmid_done", mem_done, 1'b0);
    check("rstmid_stall", stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    m_if_rdata  = '0;
    m_mem_rdata = '0;
    run_window(1'b1, 1'b1, 1'b0, 32'h200, 32'h4000, 32'h0, 2, 1, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b1; if_addr = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #2;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_if_done", if_done, 1'b0);
    check("rst_mem_done", mem_done, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_stall_if", stall, 1'b1);
    if_req = 1'b0;
    #1;
    check("rst_stall_none", stall, 1'b0);
    mem_wr = 1'b1;
    #1;
    check("rst_stall_mem", stall, 1'b1);
    mem_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_if_rdata  = '0;
    m_mem_rdata = '0;

    // Fetch only, zero-wait.
    run_window(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1, 1, 32'h00500093);
    // Store plus fetch, both zero-wait.
    run_window(1'b1, 1'b0, 1'b1, 32'h104, 32'h2000, 32'hDEADBEEF, 1, 1, 32'h0);
    // Load with ack on the third grant cycle.
    run_window(1'b0, 1'b1, 1'b0, 32'h0, 32'h3000, 32'h0, 3, 1, 32'h12345678);
    // Load whose ack never comes.
    run_window(1'b0, 1'b1, 1'b0, 32'h0, 32'h3004, 32'h0, TO + 1, 1, 32'h0);
    // Read and write together behave as a store.
    run_window(1'b0, 1'b1, 1'b1, 32'h0, 32'h3008, 32'hCAFEF00D, 1, 1, 32'h0);
    // Fetch that times out, then load, then empty window.
    run_window(1'b1, 1'b1, 1'b0, 32'h108, 32'h300C, 32'h0, 2, TO + 1, 32'h0);
    run_window(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0);

    reset_mid();

    for (int i = 0; i < 300; i++) begin
      run_window(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 $urandom, $urandom, $urandom,
                 int'($urandom_range(TO + 1, 1)), int'($urandom_range(TO + 1, 1)), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
